// File: rtl/fifo_reader.sv
// fifo_reader: drains a registered-output upstream fifo into a 2-entry
// in-order skid buffer and presents it as a valid/ready stream.
//
// Optional feature: define FIFO_READER_CNT_EN to add the word_cnt port,
// a wrapping count of delivered words.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   f_empty  in   upstream fifo empty flag
//   f_dout   in   upstream fifo read data, valid the cycle after a read
//   f_rd_en  out  upstream read strobe (combinational)
//   flush    in   discard buffered and in-flight words
//   m_data   out  head of the skid buffer
//   m_valid  out  m_data holds a valid word
//   m_ready  in   downstream accepts m_data
//   word_cnt out  delivered-word count (FIFO_READER_CNT_EN only)
module fifo_reader #(
  parameter int unsigned D_SIZE = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_empty,
  input  logic [D_SIZE-1:0] f_dout,
  output logic              f_rd_en,
  input  logic              flush,
  output logic [D_SIZE-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CNT_W-1:0]  word_cnt
`endif
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned LVL_W = 3;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("fifo_reader: CNT_W must be nonzero");
  end

  logic [OCC_W-1:0]  r_occ;
  logic              r_infl;
  logic              r_valid;
  logic [D_SIZE-1:0] r_buf0;
  logic [D_SIZE-1:0] r_buf1;

  logic [OCC_W-1:0]  w_occ_nxt;
  logic              w_infl_nxt;
  logic [D_SIZE-1:0] w_buf0_nxt;
  logic [D_SIZE-1:0] w_buf1_nxt;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level;

  assign w_pop   = r_valid && m_ready;
  // Occupancy the buffer will have once the in-flight word lands and any
  // same-edge pop has happened; a new read is allowed only if it still fits.
  assign w_level = LVL_W'(r_occ) + LVL_W'(r_infl) - LVL_W'(w_pop);
  assign f_rd_en = !rst && !f_empty && !flush && (w_level < LVL_W'(2));

  assign m_data  = r_buf0;
  assign m_valid = r_valid;

  // Next buffer state: pop shifts the queue, then the in-flight word lands at the tail.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_infl_nxt = f_rd_en;
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    if (flush) begin
      w_occ_nxt  = '0;
      w_infl_nxt = 1'b0;
    end else begin
      if (w_pop) begin
        w_buf0_nxt = r_buf1;
        w_occ_nxt  = r_occ - OCC_W'(1);
      end
      if (r_infl) begin
        if (w_occ_nxt == '0) begin
          w_buf0_nxt = f_dout;
        end else begin
          w_buf1_nxt = f_dout;
        end
        w_occ_nxt = w_occ_nxt + OCC_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= '0;
      r_infl  <= 1'b0;
      r_valid <= 1'b0;
      r_buf0  <= '0;
      r_buf1  <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_infl  <= w_infl_nxt;
      r_valid <= (w_occ_nxt != '0);
      r_buf0  <= w_buf0_nxt;
      r_buf1  <= w_buf1_nxt;
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Delivered-word counter; a pop during flush still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(w_pop);
    end
  end

  assign word_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a queue-based upstream fifo model.
module tb_fifo_reader;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_empty = 1'b1;
  logic [DW-1:0] f_dout = '0;
  logic          f_rd_en;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
`ifdef FIFO_READER_CNT_EN
  logic [3:0]    word_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] outq[$];
  int            popc[$];

  fifo_reader #(.D_SIZE(DW), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_empty (f_empty),
    .f_dout  (f_dout),
    .f_rd_en (f_rd_en),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef FIFO_READER_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Upstream fifo model and downstream monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f_rd_en && !f_empty) begin
      f_dout  <= fq.pop_front();
      rd_cnt  <= rd_cnt + 1;
      f_empty <= (fq.size() == 0);
    end
    if (m_valid && m_ready) begin
      outq.push_back(m_data);
      popc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
    f_empty <= 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", m_valid); end
    tests++;
    if (f_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %0b expected 0", f_rd_en); end
    tests++;
    if (m_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %0h expected 0", m_data); end
`ifdef FIFO_READER_CNT_EN
    tests++;
    if (word_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
`endif
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    outq.delete();
    m_ready = 1'b1;
    push_words(32'h11, 1);
    #1;
    tests++;
    if (f_rd_en !== 1'b1) begin fails++; $display("FAIL single_rd_en_c0: got %0b expected 1", f_rd_en); end
    tick(1);
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL single_valid_c1: got %0b expected 0", m_valid); end
    tick(1);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 32'h11)
      begin fails++; $display("FAIL single_c2: got v=%0b d=%0h expected v=1 d=11", m_valid, m_data); end
    tick(1);
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL single_valid_c3: got %0b expected 0", m_valid); end
    tests++;
    if (outq.size() != 1 || outq[0] !== 32'h11)
      begin fails++; $display("FAIL single_pops: got %0d pops expected 1 of 11", outq.size()); end
  endtask

  task automatic test_stream();
    int base;
    outq.delete();
    popc.delete();
    m_ready = 1'b1;
    base = cyc;
    push_words(1, 8);
    tick(12);
    tests++;
    if (outq.size() != 8) begin fails++; $display("FAIL stream_count: got %0d expected 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      tests++;
      if (outq[i] !== DW'(i + 1) || popc[i] != base + 2 + i)
        begin fails++; $display("FAIL stream_word%0d: got d=%0h cyc=%0d expected d=%0h cyc=%0d",
                                i, outq[i], popc[i], i + 1, base + 2 + i); end
    end
  endtask

  task automatic test_backpressure();
    int rb;
    outq.delete();
    m_ready = 1'b0;
    rb = rd_cnt;
    push_words(1, 5);
    tick(2);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      tests++;
      if (m_valid !== 1'b1 || m_data !== 32'd1)
        begin fails++; $display("FAIL bp_hold%0d: got v=%0b d=%0h expected v=1 d=1", k, m_valid, m_data); end
    end
    tests++;
    if (rd_cnt - rb != 2) begin fails++; $display("FAIL bp_reads: got %0d expected 2", rd_cnt - rb); end
    m_ready = 1'b1;
    tick(10);
    tests++;
    if (outq.size() != 5) begin fails++; $display("FAIL bp_count: got %0d expected 5", outq.size()); end
    for (int i = 0; i < 5 && i < outq.size(); i++) begin
      tests++;
      if (outq[i] !== DW'(i + 1))
        begin fails++; $display("FAIL bp_word%0d: got %0h expected %0h", i, outq[i], i + 1); end
    end
  endtask

  task automatic test_flush();
    outq.delete();
    m_ready = 1'b0;
    push_words(10, 4);
    tick(2);
    // one word buffered, one in flight
    flush = 1'b1;
    #1;
    tests++;
    if (f_rd_en !== 1'b0) begin fails++; $display("FAIL flush_rd_en: got %0b expected 0", f_rd_en); end
    tick(1);
    flush = 1'b0;
    tests++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b expected 0", m_valid); end
    m_ready = 1'b1;
    tick(8);
    tests++;
    if (outq.size() != 2) begin fails++; $display("FAIL flush_count: got %0d expected 2", outq.size()); end
    for (int i = 0; i < 2 && i < outq.size(); i++) begin
      tests++;
      if (outq[i] !== DW'(12 + i))
        begin fails++; $display("FAIL flush_word%0d: got %0d expected %0d", i, outq[i], 12 + i); end
    end
  endtask

  task automatic test_rst_mid();
    outq.delete();
    m_ready = 1'b0;
    push_words(20, 3);
    tick(4);
    tests++;
    if (m_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %0b expected 1", m_valid); end
    rst = 1'b1;
    fq.delete();
    f_empty <= 1'b1;
    tick(1);
    tests++;
    if (m_valid !== 1'b0 || f_rd_en !== 1'b0)
      begin fails++; $display("FAIL rstmid_c1: got v=%0b rd=%0b expected 0 0", m_valid, f_rd_en); end
`ifdef FIFO_READER_CNT_EN
    tests++;
    if (word_cnt !== 4'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d expected 0", word_cnt); end
`endif
    // fifo refilled while still in reset: no read may be issued
    push_words(99, 1);
    #1;
    tests++;
    if (f_rd_en !== 1'b0) begin fails++; $display("FAIL rstmid_rd_en: got %0b expected 0", f_rd_en); end
    tick(1);
    rst = 1'b0;
    m_ready = 1'b1;
    tick(5);
    tests++;
    if (outq.size() != 1 || outq[0] !== 32'd99)
      begin fails++; $display("FAIL rstmid_after: got %0d words expected only 99", outq.size()); end
  endtask

`ifdef FIFO_READER_CNT_EN
  task automatic test_cnt_wrap();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    outq.delete();
    m_ready = 1'b1;
    push_words(1, 17);
    tick(22);
    tests++;
    if (outq.size() != 17) begin fails++; $display("FAIL cnt_pops: got %0d expected 17", outq.size()); end
    tests++;
    if (word_cnt !== 4'd1) begin fails++; $display("FAIL cnt_wrap: got %0d expected 1", word_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_rst_mid();
`ifdef FIFO_READER_CNT_EN
    test_cnt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
